// File: rtl/axi_aw_wid_scheduler.sv
// AXI write-address scheduler: round-robin arbitration of N target-port
// AW channels onto one slave-side AW channel, with a push into the
// write-data allocator ID FIFO and an in-flight burst limit.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  ARB   | looking for an eligible requester; grant is combinational
//  HOLD  | registered address presented on the slave side until accepted
module axi_aw_wid_scheduler #(
   parameter int N_TARG_PORT     = 7,
   parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
   parameter int AW_PAYLOAD_W    = 56,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [N_TARG_PORT-1:0]                 awvalid_i,
   input  logic [N_TARG_PORT*AW_PAYLOAD_W-1:0]    awpayload_i,
   output logic [N_TARG_PORT-1:0]                 awready_o,
   output logic                                   awvalid_o,
   output logic [AW_PAYLOAD_W-1:0]                awpayload_o,
   input  logic                                   awready_i,
   output logic                                   push_ID_o,
   output logic [LOG_N_TARG+N_TARG_PORT-1:0]      ID_o,
   input  logic                                   id_grant_i,
   input  logic                                   b_done_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

   // a single port has a zero-width binary index; keep internal pointers at least 1 bit
   localparam int PTR_W = (LOG_N_TARG > 0) ? LOG_N_TARG : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PTR_W:0]   N_EXT   = (PTR_W+1)'(N_TARG_PORT);
   localparam logic [PTR_W-1:0] LAST    = PTR_W'(N_TARG_PORT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic {ST_ARB, ST_HOLD} state_t;

   state_t                   r_state;
   logic [PTR_W-1:0]         r_rr_ptr;
   logic [CNT_W-1:0]         r_outstanding;
   logic                     r_awvalid;
   logic [AW_PAYLOAD_W-1:0]  r_awpayload;

   logic                     w_found;
   logic [PTR_W-1:0]         w_win;
   logic [PTR_W:0]           w_idx;
   logic [N_TARG_PORT-1:0]   w_win_oh;
   logic                     w_elig;
   logic                     w_dec;

   // Round-robin search: first valid port at or above rr_ptr, wrapping to 0
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
         if (w_idx >= N_EXT) begin
            w_idx = w_idx - N_EXT;
         end
         if (!w_found && awvalid_i[w_idx[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[PTR_W-1:0];
         end
      end
   end

   // One-hot form of the winner index
   always_comb begin
      w_win_oh = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         w_win_oh[i] = (w_win == PTR_W'(i));
      end
   end

   // Grant is suppressed during reset, while holding, when the ID FIFO is full
   // or when the in-flight limit is reached
   assign w_elig = rst_n && (r_state == ST_ARB) && w_found && id_grant_i &&
                   (r_outstanding < CNT_MAX);
   assign w_dec  = b_done_i && (r_outstanding != '0);

   assign awready_o     = w_elig ? w_win_oh : '0;
   assign push_ID_o     = w_elig;
   assign awvalid_o     = r_awvalid;
   assign awpayload_o   = r_awpayload;
   assign outstanding_o = r_outstanding;

   generate
      if (LOG_N_TARG > 0) begin : g_id_multi
         assign ID_o = w_elig ? {w_win, w_win_oh} : '0;
      end else begin : g_id_single
         assign ID_o = w_elig ? w_win_oh : '0;
      end
   endgenerate

   // Arbitration FSM with registered slave-side address and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ARB;
         r_rr_ptr    <= '0;
         r_awvalid   <= 1'b0;
         r_awpayload <= '0;
      end else begin
         case (r_state)
            ST_ARB: begin
               if (w_elig) begin
                  r_state     <= ST_HOLD;
                  r_awvalid   <= 1'b1;
                  r_awpayload <= awpayload_i[w_win*AW_PAYLOAD_W +: AW_PAYLOAD_W];
                  r_rr_ptr    <= (w_win == LAST) ? '0 : w_win + PTR_W'(1);
               end
            end
            ST_HOLD: begin
               if (awready_i) begin
                  r_state   <= ST_ARB;
                  r_awvalid <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_ARB;
               r_awvalid <= 1'b0;
            end
         endcase
      end
   end

   // In-flight burst count: up on push, down on a B completion, hold on both
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outstanding <= '0;
      end else if (w_elig && !w_dec) begin
         r_outstanding <= r_outstanding + CNT_W'(1);
      end else if (!w_elig && w_dec) begin
         r_outstanding <= r_outstanding - CNT_W'(1);
      end
   end

endmodule
